// File: rtl/aes_key_sched_arb.sv
// Round-robin scheduler sharing one AES key-expansion pipeline among N_REQ requesters,
// with a one-entry cache of the last expanded key.
module aes_key_sched_arb #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned KEY_WIDTH = 256,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*KEY_WIDTH-1:0] req_key,
  input  logic [N_REQ*8-1:0]         req_flag,
  output logic [N_REQ-1:0]           rsp_valid,
  input  logic [N_REQ-1:0]           rsp_ready,
  output logic [1023:0]              rsp_data,
  output logic                       rsp_err,
  output logic [KEY_WIDTH-1:0]       exp_key,
  output logic                       exp_key_valid,
  input  logic [2047:0]              exp_full,
  input  logic                       exp_full_valid,
  output logic                       busy
);
  localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT) + 1;
  localparam int unsigned HALF_W = 1024;
  localparam int unsigned FULL_W = 2048;
  localparam logic [7:0]  FLAG_LO = 8'h01;
  localparam logic [7:0]  FLAG_HI = 8'h02;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, id_q, win_idx;
  logic                 win_found, win_flag_ok, win_hit, timeout;
  logic [KEY_WIDTH-1:0] win_key, key_q, cache_key_q;
  logic [7:0]           win_flag, flag_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [FULL_W-1:0]    cache_data_q;
  logic                 cache_valid_q;

  function automatic logic [HALF_W-1:0] pick_half(input logic [FULL_W-1:0] full,
                                                  input logic [7:0] flag);
    return (flag == FLAG_HI) ? full[FULL_W-1:HALF_W] : full[HALF_W-1:0];
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Rotating-priority search: first valid requester at or above ptr_q, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!win_found && req_valid[IDX_W'((32'(ptr_q) + k) % N_REQ)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'((32'(ptr_q) + k) % N_REQ);
      end
    end
  end

  assign win_key     = req_key[32'(win_idx) * KEY_WIDTH +: KEY_WIDTH];
  assign win_flag    = req_flag[32'(win_idx) * 8 +: 8];
  assign win_flag_ok = (win_flag == FLAG_LO) || (win_flag == FLAG_HI);
  assign win_hit     = cache_valid_q && (win_key == cache_key_q);
  assign timeout     = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          req_ready = onehot(win_idx);
          state_d   = (!win_flag_ok || win_hit) ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      // A result arriving on the timeout cycle still counts as success.
      ST_WAIT:  if (exp_full_valid || timeout) state_d = ST_RESP;
      ST_RESP:  if (rsp_ready[id_q]) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      ptr_q         <= '0;
      id_q          <= '0;
      key_q         <= '0;
      flag_q        <= '0;
      cnt_q         <= '0;
      cache_data_q  <= '0;
      cache_key_q   <= '0;
      cache_valid_q <= 1'b0;
      rsp_valid     <= '0;
      rsp_data      <= '0;
      rsp_err       <= 1'b0;
      exp_key       <= '0;
      exp_key_valid <= 1'b0;
      busy          <= 1'b0;
    end else begin
      exp_key_valid <= (state_d == ST_ISSUE);
      busy          <= (state_d != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            ptr_q  <= (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
            id_q   <= win_idx;
            key_q  <= win_key;
            flag_q <= win_flag;
            if (!win_flag_ok) begin
              rsp_valid <= onehot(win_idx);
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
            end else if (win_hit) begin
              rsp_valid <= onehot(win_idx);
              rsp_err   <= 1'b0;
              rsp_data  <= pick_half(cache_data_q, win_flag);
            end else begin
              exp_key <= win_key;
            end
          end
        end
        ST_ISSUE: cnt_q <= '0;
        ST_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (exp_full_valid) begin
            cache_data_q  <= exp_full;
            cache_key_q   <= key_q;
            cache_valid_q <= 1'b1;
            rsp_valid     <= onehot(id_q);
            rsp_err       <= 1'b0;
            rsp_data      <= pick_half(exp_full, flag_q);
          end else if (timeout) begin
            cache_valid_q <= 1'b0;
            rsp_valid     <= onehot(id_q);
            rsp_err       <= 1'b1;
            rsp_data      <= '0;
          end
        end
        ST_RESP: begin
          if (rsp_ready[id_q]) begin
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_key_sched_arb.sv
// Self-checking bench for aes_key_sched_arb: scoreboarded responses, bench-side cache model,
// cycle-accurate latency and timeout checks.
module tb_aes_key_sched_arb;
  localparam int unsigned N_REQ = 4;
  localparam int unsigned KW    = 256;
  localparam int unsigned TO    = 64;

  logic                clock = 1'b0;
  logic                resetn;
  logic [N_REQ-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N_REQ*KW-1:0] req_key;
  logic [N_REQ*8-1:0]  req_flag;
  logic [1023:0]       rsp_data;
  logic                rsp_err;
  logic [KW-1:0]       exp_key;
  logic                exp_key_valid;
  logic [2047:0]       exp_full;
  logic                exp_full_valid;
  logic                busy;

  aes_key_sched_arb #(.N_REQ(N_REQ), .KEY_WIDTH(KW), .TIMEOUT(TO)) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key), .req_flag(req_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .exp_key(exp_key), .exp_key_valid(exp_key_valid),
    .exp_full(exp_full), .exp_full_valid(exp_full_valid), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct { int id; logic [1023:0] data; logic err; } exp_t;
  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  int issue_cnt = 0;
  logic          mdl_valid = 1'b0;
  logic [KW-1:0] mdl_key = '0;

  localparam logic [KW-1:0] K1 = {8{32'hA11C_E001}};
  localparam logic [KW-1:0] K2 = {8{32'hB0B0_2222}};
  localparam logic [KW-1:0] K5 = {8{32'h5555_F00D}};

  always @(posedge clock) cyc_n <= cyc_n + 1;
  always @(negedge clock) if (exp_key_valid === 1'b1) issue_cnt <= issue_cnt + 1;

  // Pipeline reference: every key expands to this pattern.
  function automatic logic [2047:0] full_of(input logic [KW-1:0] k);
    logic [2047:0] f;
    for (int i = 0; i < 8; i++) f[i*256 +: 256] = k ^ {8{32'(i) * 32'h0101_0101 + 32'h5A}};
    return f;
  endfunction

  function automatic logic [1023:0] half_of(input logic [2047:0] f, input logic [7:0] flag);
    return (flag == 8'h02) ? f[2047:1024] : f[1023:0];
  endfunction

  function automatic logic [N_REQ-1:0] oh(input int i);
    logic [N_REQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [KW-1:0] rr_key(input int i);
    return {8{32'hC0DE_0000 + 32'(i)}};
  endfunction

  function automatic exp_t model(input int id, input logic [KW-1:0] k, input logic [7:0] f);
    exp_t e;
    e.id = id;
    if (f != 8'h01 && f != 8'h02) begin
      e.err = 1'b1; e.data = '0;
    end else begin
      e.err = 1'b0; e.data = half_of(full_of(k), f);
    end
    return e;
  endfunction

  function automatic bit model_miss(input logic [KW-1:0] k, input logic [7:0] f);
    return (f == 8'h01 || f == 8'h02) && !(mdl_valid && k == mdl_key);
  endfunction

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic post(input int i, input logic [KW-1:0] k, input logic [7:0] f);
    req_key[i*KW +: KW] = k;
    req_flag[i*8 +: 8]  = f;
    req_valid[i]        = 1'b1;
  endtask

  task automatic wait_grant(input int budget, output int w, output bit ok);
    ok = 1'b0;
    w  = -1;
    for (int n = 0; n <= budget; n++) begin
      #1;
      if (req_ready != '0) begin
        ok = 1'b1;
        for (int j = 0; j < N_REQ; j++) if (req_ready[j]) w = j;
        break;
      end
      step();
    end
  endtask

  // Called in the ISSUE cycle: result is presented lat cycles later.
  task automatic pipe_pulse(input int lat, input logic [2047:0] f);
    repeat (lat) step();
    exp_full = f;
    exp_full_valid = 1'b1;
    step();
    exp_full_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output int waited, output bit ok);
    waited = 0;
    while (rsp_valid === '0 && waited < budget) begin
      step();
      waited++;
    end
    ok = (rsp_valid !== '0);
  endtask

  task automatic release_rsp(input int id);
    rsp_ready[id] = 1'b1;
    step();
    rsp_ready[id] = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) step();
    total++; if (rsp_valid !== '0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    total++; if (exp_key_valid !== 1'b0 || exp_key !== '0) begin bad++; $display("FAIL reset_exp: got v=%b key=%h want 0", exp_key_valid, exp_key[31:0]); end
    total++; if (busy !== 1'b0 || rsp_err !== 1'b0) begin bad++; $display("FAIL reset_busy_err: got busy=%b err=%b want 0", busy, rsp_err); end
    total++; if (rsp_data !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", rsp_data[63:0]); end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_single_miss();
    int w, a_cyc, i0, waited;
    bit ok, rok;
    exp_t e;
    i0 = issue_cnt;
    post(0, K1, 8'h01);
    sb.push_back(model(0, K1, 8'h01));
    wait_grant(5, w, ok);
    a_cyc = cyc_n;
    total++; if (!ok || req_ready !== 4'b0001) begin bad++; $display("FAIL miss_grant: got %b want 0001", req_ready); end
    step();
    req_valid[0] = 1'b0;
    total++; if (exp_key_valid !== 1'b1 || exp_key !== K1) begin bad++; $display("FAIL miss_issue: got v=%b key=%h want v=1 key=%h", exp_key_valid, exp_key[31:0], K1[31:0]); end
    repeat (13) step();
    total++; if (rsp_valid !== '0 || busy !== 1'b1) begin bad++; $display("FAIL miss_early: got rsp=%b busy=%b want 0/1", rsp_valid, busy); end
    step();
    exp_full = full_of(K1);
    exp_full_valid = 1'b1;
    step();
    exp_full_valid = 1'b0;
    wait_rsp(4, waited, rok);
    total++; if (!rok || cyc_n - a_cyc !== 16) begin bad++; $display("FAIL miss_latency: got %0d want 16", cyc_n - a_cyc); end
    total++; if (issue_cnt - i0 !== 1) begin bad++; $display("FAIL miss_issue_count: got %0d want 1", issue_cnt - i0); end
    e = sb.pop_front();
    total++; if (rsp_valid !== oh(e.id) || rsp_data !== e.data || rsp_err !== e.err) begin bad++; $display("FAIL miss_rsp: got v=%b err=%b data=%h want v=%b err=%b data=%h", rsp_valid, rsp_err, rsp_data[63:0], oh(e.id), e.err, e.data[63:0]); end
    release_rsp(0);
    total++; if (rsp_valid !== '0 || busy !== 1'b0) begin bad++; $display("FAIL miss_release: got rsp=%b busy=%b want 0/0", rsp_valid, busy); end
    mdl_valid = 1'b1;
    mdl_key = K1;
  endtask

  task automatic test_cache_hit();
    int w, i0;
    bit ok;
    exp_t e;
    i0 = issue_cnt;
    post(2, K1, 8'h02);
    sb.push_back(model(2, K1, 8'h02));
    wait_grant(5, w, ok);
    total++; if (!ok || w !== 2) begin bad++; $display("FAIL hit_grant: got %0d want 2", w); end
    step();
    req_valid[2] = 1'b0;
    e = sb.pop_front();
    total++; if (rsp_valid !== oh(e.id) || rsp_data !== e.data || rsp_err !== e.err) begin bad++; $display("FAIL hit_rsp: got v=%b err=%b data=%h want v=%b err=%b data=%h", rsp_valid, rsp_err, rsp_data[63:0], oh(e.id), e.err, e.data[63:0]); end
    total++; if (issue_cnt !== i0) begin bad++; $display("FAIL hit_no_issue: got %0d want %0d", issue_cnt, i0); end
    release_rsp(2);
  endtask

  task automatic test_round_robin();
    int order[7] = '{0, 1, 2, 3, 0, 3, 0};
    logic [3:0] masks[7] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h9, 4'h9};
    int w, waited;
    bit ok, rok;
    exp_t e;
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    step();
    mdl_valid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      req_key[i*KW +: KW] = rr_key(i);
      req_flag[i*8 +: 8]  = 8'h01;
    end
    for (int n = 0; n < 7; n++) begin
      req_valid = masks[n];
      wait_grant(8, w, ok);
      total++; if (!ok || w !== order[n]) begin bad++; $display("FAIL rr_grant_%0d: got %0d want %0d", n, w, order[n]); end
      if (ok) begin
        sb.push_back(model(w, rr_key(w), 8'h01));
        step();
        if (model_miss(rr_key(w), 8'h01)) begin
          pipe_pulse(2, full_of(rr_key(w)));
          mdl_valid = 1'b1;
          mdl_key = rr_key(w);
        end
        wait_rsp(TO + 8, waited, rok);
        e = sb.pop_front();
        total++; if (!rok || rsp_valid !== oh(e.id) || rsp_data !== e.data || rsp_err !== e.err) begin bad++; $display("FAIL rr_rsp_%0d: got v=%b err=%b data=%h want v=%b err=%b data=%h", n, rsp_valid, rsp_err, rsp_data[63:0], oh(e.id), e.err, e.data[63:0]); end
        release_rsp(e.id);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_errors();
    int w, i0, n, waited;
    bit ok, rok;
    exp_t e;
    logic [KW-1:0] kc;
    kc = mdl_key;
    i0 = issue_cnt;
    post(1, K2, 8'h05);
    sb.push_back(model(1, K2, 8'h05));
    wait_grant(5, w, ok);
    step();
    req_valid[1] = 1'b0;
    e = sb.pop_front();
    total++; if (!ok || rsp_valid !== oh(e.id) || rsp_err !== 1'b1 || rsp_data !== '0 || issue_cnt !== i0) begin bad++; $display("FAIL err_flag: got v=%b err=%b data=%h issues=%0d want v=%b err=1 data=0 issues=%0d", rsp_valid, rsp_err, rsp_data[63:0], issue_cnt, oh(e.id), i0); end
    release_rsp(1);
    // Silent pipeline: error lands exactly TO cycles into WAIT.
    post(1, K2, 8'h01);
    sb.push_back('{id: 1, data: '0, err: 1'b1});
    wait_grant(5, w, ok);
    step();
    req_valid[1] = 1'b0;
    total++; if (exp_key_valid !== 1'b1 || exp_key !== K2) begin bad++; $display("FAIL to_issue: got v=%b key=%h want v=1 key=%h", exp_key_valid, exp_key[31:0], K2[31:0]); end
    n = 0;
    while (rsp_valid === '0 && n < TO + 20) begin
      step();
      n++;
    end
    total++; if (n !== TO + 1) begin bad++; $display("FAIL to_cycles: got %0d want %0d", n, TO + 1); end
    e = sb.pop_front();
    total++; if (rsp_valid !== oh(e.id) || rsp_err !== e.err || rsp_data !== e.data) begin bad++; $display("FAIL to_rsp: got v=%b err=%b data=%h want v=%b err=1 data=0", rsp_valid, rsp_err, rsp_data[63:0], oh(e.id)); end
    release_rsp(1);
    mdl_valid = 1'b0;
    // Previously cached key must expand again after the timeout.
    i0 = issue_cnt;
    post(0, kc, 8'h02);
    sb.push_back(model(0, kc, 8'h02));
    wait_grant(5, w, ok);
    step();
    req_valid[0] = 1'b0;
    total++; if (exp_key_valid !== 1'b1 || exp_key !== kc) begin bad++; $display("FAIL to_reissue: got v=%b key=%h want v=1 key=%h", exp_key_valid, exp_key[31:0], kc[31:0]); end
    pipe_pulse(3, full_of(kc));
    mdl_valid = 1'b1;
    mdl_key = kc;
    wait_rsp(4, waited, rok);
    e = sb.pop_front();
    total++; if (!rok || rsp_valid !== oh(e.id) || rsp_data !== e.data || rsp_err !== e.err) begin bad++; $display("FAIL to_reissue_rsp: got v=%b err=%b data=%h want v=%b err=%b data=%h", rsp_valid, rsp_err, rsp_data[63:0], oh(e.id), e.err, e.data[63:0]); end
    release_rsp(0);
  endtask

  task automatic test_backpressure();
    int w, i0;
    bit ok, stable, noacc;
    exp_t e;
    logic [1023:0] d0;
    logic [KW-1:0] kc;
    kc = mdl_key;
    i0 = issue_cnt;
    post(3, kc, 8'h01);
    sb.push_back(model(3, kc, 8'h01));
    wait_grant(5, w, ok);
    step();
    req_valid[3] = 1'b0;
    e = sb.pop_front();
    total++; if (!ok || rsp_valid !== oh(e.id) || rsp_data !== e.data || rsp_err !== e.err) begin bad++; $display("FAIL bp_rsp: got v=%b err=%b data=%h want v=%b err=%b data=%h", rsp_valid, rsp_err, rsp_data[63:0], oh(e.id), e.err, e.data[63:0]); end
    d0 = rsp_data;
    post(0, kc, 8'h02);
    rsp_ready[1] = 1'b1;
    stable = 1'b1;
    noacc = 1'b1;
    for (int n = 0; n < 10; n++) begin
      step();
      if (rsp_valid !== 4'b1000 || rsp_data !== d0 || rsp_err !== 1'b0 || busy !== 1'b1) stable = 1'b0;
      if (req_ready !== '0) noacc = 1'b0;
    end
    rsp_ready[1] = 1'b0;
    total++; if (!stable) begin bad++; $display("FAIL bp_hold: got v=%b busy=%b want v=1000 busy=1 held", rsp_valid, busy); end
    total++; if (!noacc) begin bad++; $display("FAIL bp_no_accept: got ready=%b want 0000", req_ready); end
    release_rsp(3);
    total++; if (rsp_valid !== '0) begin bad++; $display("FAIL bp_release: got %b want 0", rsp_valid); end
    sb.push_back(model(0, kc, 8'h02));
    wait_grant(3, w, ok);
    step();
    req_valid[0] = 1'b0;
    e = sb.pop_front();
    total++; if (!ok || w !== 0 || rsp_valid !== oh(e.id) || rsp_data !== e.data) begin bad++; $display("FAIL bp_next: got w=%0d v=%b data=%h want w=0 v=%b data=%h", w, rsp_valid, rsp_data[63:0], oh(e.id), e.data[63:0]); end
    release_rsp(0);
    // Spurious result while idle must not disturb the cache.
    exp_full = ~full_of(kc);
    exp_full_valid = 1'b1;
    step();
    exp_full_valid = 1'b0;
    total++; if (busy !== 1'b0 || rsp_valid !== '0) begin bad++; $display("FAIL spur_state: got busy=%b v=%b want 0/0", busy, rsp_valid); end
    post(2, kc, 8'h01);
    sb.push_back(model(2, kc, 8'h01));
    wait_grant(3, w, ok);
    step();
    req_valid[2] = 1'b0;
    e = sb.pop_front();
    total++; if (rsp_valid !== oh(e.id) || rsp_data !== e.data || issue_cnt !== i0) begin bad++; $display("FAIL spur_cache: got v=%b data=%h issues=%0d want v=%b data=%h issues=%0d", rsp_valid, rsp_data[63:0], issue_cnt, oh(e.id), e.data[63:0], i0); end
    release_rsp(2);
  endtask

  task automatic test_reset_in_wait();
    int w, waited;
    bit ok, rok;
    exp_t e;
    post(2, K5, 8'h01);
    wait_grant(5, w, ok);
    step();
    req_valid[2] = 1'b0;
    total++; if (exp_key_valid !== 1'b1) begin bad++; $display("FAIL rw_issue: got %b want 1", exp_key_valid); end
    repeat (3) step();
    resetn = 1'b0;
    step();
    total++; if (rsp_valid !== '0 || busy !== 1'b0 || exp_key_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_data !== '0 || exp_key !== '0) begin bad++; $display("FAIL rw_outputs: got v=%b busy=%b ekv=%b err=%b want all 0", rsp_valid, busy, exp_key_valid, rsp_err); end
    resetn = 1'b1;
    mdl_valid = 1'b0;
    exp_full = full_of(K5);
    exp_full_valid = 1'b1;
    step();
    exp_full_valid = 1'b0;
    step();
    total++; if (busy !== 1'b0 || rsp_valid !== '0) begin bad++; $display("FAIL rw_late: got busy=%b v=%b want 0/0", busy, rsp_valid); end
    post(2, K5, 8'h02);
    sb.push_back(model(2, K5, 8'h02));
    wait_grant(5, w, ok);
    step();
    req_valid[2] = 1'b0;
    total++; if (!ok || exp_key_valid !== 1'b1 || exp_key !== K5) begin bad++; $display("FAIL rw_miss: got v=%b key=%h want v=1 key=%h", exp_key_valid, exp_key[31:0], K5[31:0]); end
    pipe_pulse(5, full_of(K5));
    wait_rsp(4, waited, rok);
    e = sb.pop_front();
    total++; if (!rok || rsp_valid !== oh(e.id) || rsp_data !== e.data || rsp_err !== e.err) begin bad++; $display("FAIL rw_rsp: got v=%b err=%b data=%h want v=%b err=%b data=%h", rsp_valid, rsp_err, rsp_data[63:0], oh(e.id), e.err, e.data[63:0]); end
    release_rsp(2);
  endtask

  initial begin
    resetn = 1'b0;
    req_valid = '0;
    req_key = '0;
    req_flag = '0;
    rsp_ready = '0;
    exp_full = '0;
    exp_full_valid = 1'b0;
    test_reset();
    test_single_miss();
    test_cache_hit();
    test_round_robin();
    test_errors();
    test_backpressure();
    test_reset_in_wait();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_drain: got %0d left want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit want finish");
    $fatal(1, "watchdog");
  end
endmodule
